// File: rtl/melody_pkg.sv
// Shared types, field widths, note divisors and the song table for the melody sequencer.
// Each song ROM entry is {note divisor, duration in ticks}; dur=0 ends a song.
package melody_pkg;

   localparam int NOTE_W    = 12;
   localparam int DUR_W     = 4;
   localparam int ROM_LEN   = 16;
   localparam int ROM_IDX_W = $clog2(ROM_LEN);
   localparam int ST_W      = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_NOTE = 3'd2,
      ST_GAP  = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] n;
      logic [DUR_W-1:0]  dur;
   } rom_entry_t;

   localparam logic [NOTE_W-1:0] REST    = 12'd0;
   localparam logic [NOTE_W-1:0] NOTE_C4 = 12'd3822;
   localparam logic [NOTE_W-1:0] NOTE_E4 = 12'd3034;
   localparam logic [NOTE_W-1:0] NOTE_G4 = 12'd2551;
   localparam logic [NOTE_W-1:0] NOTE_C5 = 12'd1911;

   function automatic rom_entry_t song_rom(input logic [1:0]           song,
                                           input logic [ROM_IDX_W-1:0] idx);
      rom_entry_t e;
      e = '{n: REST, dur: '0};
      case (song)
         2'd0: case (idx)
            4'd0:    e = '{n: 12'd100, dur: 4'd2};
            4'd1:    e = '{n: REST,    dur: 4'd1};
            4'd2:    e = '{n: 12'd200, dur: 4'd1};
            default: e = '{n: REST,    dur: 4'd0};
         endcase
         2'd1: case (idx)
            4'd0:    e = '{n: NOTE_C4, dur: 4'd2};
            4'd1:    e = '{n: NOTE_E4, dur: 4'd2};
            4'd2:    e = '{n: NOTE_G4, dur: 4'd2};
            4'd3:    e = '{n: NOTE_C5, dur: 4'd4};
            default: e = '{n: REST,    dur: 4'd0};
         endcase
         2'd2: case (idx)
            4'd0:    e = '{n: NOTE_G4, dur: 4'd1};
            4'd1:    e = '{n: REST,    dur: 4'd1};
            4'd2:    e = '{n: NOTE_G4, dur: 4'd1};
            4'd3:    e = '{n: NOTE_E4, dur: 4'd3};
            4'd4:    e = '{n: NOTE_C4, dur: 4'd1};
            default: e = '{n: REST,    dur: 4'd0};
         endcase
         // Full-length song without terminator: every slot is a distinct short note.
         default: e = '{n: NOTE_W'(256) + NOTE_W'({idx, 4'h0}), dur: 4'd1};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/dur_tick_gen.sv
// Free-running duration tick: one-cycle pulse every TICK_CYCLES clocks, restarted by clr.
module dur_tick_gen #(
   parameter int TICK_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int            CNT_W = $clog2(TICK_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Song player: steps the selected ROM song, driving note divisor N and tone gate per entry.
// play/stop are level requests sampled every clock; there is no valid/ready pairing.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_CYCLES = 2_500_000,
   parameter int GAP_TICKS   = 1,
   parameter int SONG_LEN    = ROM_LEN,
   parameter int N_W         = NOTE_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           play,
   input  logic           stop,
   input  logic [1:0]     song_sel,
   output logic [N_W-1:0] N,
   output logic           tone_en,
   output logic           busy,
   output logic           done,
   output logic [ST_W-1:0] state_dbg
);

   localparam int IDX_W = $clog2(SONG_LEN);
   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   if (TICK_CYCLES < 2 || TICK_CYCLES > CLK_HZ) begin : g_bad_tick
      $error("melody_sequencer: TICK_CYCLES must lie in [2, CLK_HZ]");
   end

   state_t           state_q, state_d;
   logic [1:0]       song_q;
   logic [IDX_W-1:0] idx_q;
   logic [N_W-1:0]   n_q;
   logic [DUR_W-1:0] dur_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             tick;
   logic             tick_clr;
   logic             last_idx;
   rom_entry_t       rom_entry;

   assign rom_entry = song_rom(song_q, ROM_IDX_W'(idx_q));
   assign last_idx  = (idx_q == IDX_W'(SONG_LEN - 1));
   assign state_dbg = state_q;

   // Tick phase restarts on every note entry; NOTE->GAP happens on a wrap, so GAP starts aligned too.
   assign tick_clr = (state_q != ST_NOTE) && (state_q != ST_GAP);

   dur_tick_gen #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .clr  (tick_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (play && !stop) state_d = ST_LOAD;
         ST_LOAD: state_d = (rom_entry.dur == '0) ? ST_FIN : ST_NOTE;
         ST_NOTE: begin
            if (tick && dur_cnt == DUR_W'(1)) begin
               if (last_idx)            state_d = ST_FIN;
               else if (GAP_TICKS == 0) state_d = ST_LOAD;
               else                     state_d = ST_GAP;
            end
         end
         ST_GAP:  if (tick && gap_cnt == GAP_W'(1)) state_d = ST_LOAD;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (stop && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         song_q  <= '0;
         idx_q   <= '0;
         n_q     <= '0;
         dur_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            song_q <= song_sel;
            idx_q  <= '0;
         end
         if (state_q == ST_LOAD && state_d == ST_NOTE) begin
            n_q     <= N_W'(rom_entry.n);
            dur_cnt <= rom_entry.dur;
         end
         if (state_q == ST_NOTE && tick) dur_cnt <= dur_cnt - DUR_W'(1);
         if (state_q == ST_NOTE && state_d == ST_GAP) gap_cnt <= GAP_W'(GAP_TICKS);
         if (state_q == ST_GAP && tick) gap_cnt <= gap_cnt - GAP_W'(1);
         if (state_d == ST_LOAD && (state_q == ST_NOTE || state_q == ST_GAP)) begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   // Outputs decode from state so an asynchronous reset silences them at once.
   always_comb begin
      N       = '0;
      tone_en = 1'b0;
      busy    = (state_q != ST_IDLE);
      done    = (state_q == ST_FIN);
      if (state_q == ST_NOTE) begin
         N       = n_q;
         tone_en = |n_q;
      end
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized self-checking bench: expected per-cycle output traces are built from the song rules.
module tb_melody_sequencer;

   localparam int TICK = 4;
   localparam int GAP  = 1;
   localparam int NW   = 12;
   localparam int W    = NW + 3;

   logic          clk;
   logic          reset;
   logic          play;
   logic          stop;
   logic [1:0]    song_sel;
   logic [NW-1:0] N;
   logic          tone_en;
   logic          busy;
   logic          done;
   logic [2:0]    state_dbg;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   melody_sequencer #(
      .TICK_CYCLES(TICK),
      .GAP_TICKS  (GAP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .play     (play),
      .stop     (stop),
      .song_sel (song_sel),
      .N        (N),
      .tone_en  (tone_en),
      .busy     (busy),
      .done     (done),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] ref_entry(input int song, input int i);
      case (song)
         0: case (i)
            0: return {12'd100, 4'd2};
            1: return {12'd0, 4'd1};
            2: return {12'd200, 4'd1};
            default: return 16'd0;
         endcase
         1: case (i)
            0: return {12'd3822, 4'd2};
            1: return {12'd3034, 4'd2};
            2: return {12'd2551, 4'd2};
            3: return {12'd1911, 4'd4};
            default: return 16'd0;
         endcase
         2: case (i)
            0: return {12'd2551, 4'd1};
            1: return {12'd0, 4'd1};
            2: return {12'd2551, 4'd1};
            3: return {12'd3034, 4'd3};
            4: return {12'd3822, 4'd1};
            default: return 16'd0;
         endcase
         default: return {12'(256 + 16 * i), 4'd1};
      endcase
   endfunction

   // Per-cycle expectation from the first cycle after the play edge to the first idle cycle.
   task automatic build_trace(input int song);
      logic [15:0]   e;
      logic [NW-1:0] n;
      int            dur;
      exp_q.delete();
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({12'd0, 3'b010});
         e   = ref_entry(song, i);
         n   = e[15:4];
         dur = int'(e[3:0]);
         if (dur == 0) break;
         repeat (dur * TICK) exp_q.push_back({n, (n != 12'd0), 1'b1, 1'b0});
         if (i == 15) break;
         repeat (GAP * TICK) exp_q.push_back({12'd0, 3'b010});
      end
      exp_q.push_back({12'd0, 3'b011});
      exp_q.push_back({12'd0, 3'b000});
   endtask

   function automatic logic [W-1:0] obs();
      return {N, tone_en, busy, done};
   endfunction

   // ---------------- driver + scoreboard ----------------
   task automatic play_and_check(input int song, input bit noise, input string name,
                                 output int onsets, output int dones);
      logic [W-1:0]  exp;
      logic [W-1:0]  got;
      logic [NW-1:0] prev_n;
      int            cyc;
      build_trace(song);
      onsets   = 0;
      dones    = 0;
      prev_n   = '0;
      cyc      = 0;
      song_sel = 2'(song);
      stop     = 1'b0;
      play     = 1'b1;
      @(negedge clk);
      play = 1'b0;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = obs();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s song %0d cycle %0d: got N=%0d tone_en=%0b busy=%0b done=%0b, want N=%0d tone_en=%0b busy=%0b done=%0b",
                     name, song, cyc, got[W-1:3], got[2], got[1], got[0],
                     exp[W-1:3], exp[2], exp[1], exp[0]);
         end
         if (N != '0 && prev_n == '0) onsets++;
         prev_n = N;
         if (done) dones++;
         if (noise) begin
            play     = (exp_q.size() > 0) && ($urandom_range(0, 3) == 0);
            song_sel = 2'($urandom_range(0, 3));
         end
         cyc++;
         @(negedge clk);
      end
      play = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; play = 1'b0; stop = 1'b0; song_sel = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL reset_hold: got %h, want 0", obs());
      end
      reset = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %h, want 0", c, obs());
         end
      end
   endtask

   task automatic test_song0_full();
      int on, dn;
      play_and_check(0, 1'b0, "song0_full", on, dn);
      checks++;
      if (on != 2 || dn != 1) begin
         errors++;
         $display("FAIL song0_counts: got onsets=%0d dones=%0d, want onsets=2 dones=1", on, dn);
      end
   endtask

   task automatic test_abort();
      logic [W-1:0] exp;
      int on, dn;
      build_trace(0);
      song_sel = 2'd0; stop = 1'b0; play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      for (int c = 0; c < 4; c++) begin
         exp = exp_q.pop_front();
         checks++;
         if (obs() !== exp) begin
            errors++;
            $display("FAIL abort_prefix cycle %0d: got %h, want %h", c, obs(), exp);
         end
         if (c == 3) stop = 1'b1;
         @(negedge clk);
      end
      stop = 1'b0;
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL abort_idle cycle %0d: got %h, want 0", c, obs());
         end
         @(negedge clk);
      end
      play_and_check(0, 1'b0, "abort_restart", on, dn);
      checks++;
      if (on != 2 || dn != 1) begin
         errors++;
         $display("FAIL abort_restart_counts: got onsets=%0d dones=%0d, want 2 and 1", on, dn);
      end
   endtask

   task automatic test_ignored_requests();
      int on, dn;
      play_and_check(0, 1'b1, "replay_mid_song", on, dn);
      play = 1'b1; stop = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL play_stop_idle cycle %0d: got %h, want 0", c, obs());
         end
      end
      play = 1'b0; stop = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL play_stop_after: got busy=%0b, want 0", busy);
      end
   endtask

   task automatic test_no_terminator();
      int on, dn;
      play_and_check(3, 1'b0, "no_terminator", on, dn);
      checks++;
      if (on != 16 || dn != 1) begin
         errors++;
         $display("FAIL no_terminator_counts: got onsets=%0d dones=%0d, want 16 and 1", on, dn);
      end
   endtask

   task automatic test_random_songs();
      int on, dn, song, idle;
      for (int r = 0; r < 6; r++) begin
         song = $urandom_range(0, 3);
         play_and_check(song, 1'($urandom_range(0, 1)), "random_song", on, dn);
         idle = $urandom_range(0, 3);
         for (int c = 0; c < idle; c++) begin
            checks++;
            if (obs() !== '0) begin
               errors++;
               $display("FAIL random_idle run %0d: got %h, want 0", r, obs());
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_async_reset();
      song_sel = 2'd1; stop = 1'b0; play = 1'b1;
      @(negedge clk);
      play = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (N !== 12'd3822 || tone_en !== 1'b1) begin
         errors++;
         $display("FAIL async_pre: got N=%0d tone_en=%0b, want N=3822 tone_en=1", N, tone_en);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (obs() !== '0) begin
         errors++;
         $display("FAIL async_drop: got %h, want 0 before next edge", obs());
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         checks++;
         if (obs() !== '0) begin
            errors++;
            $display("FAIL async_after cycle %0d: got %h, want 0", c, obs());
         end
      end
   endtask

   initial begin
      test_reset();
      test_song0_full();
      test_abort();
      test_ignored_requests();
      test_no_terminator();
      test_random_songs();
      test_async_reset();
      test_song0_full();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the buzzer tone generator (`Top`).
- Plays short stored songs by driving the 12-bit note divisor `N` and a gate enable for the bell PWM path.
- On a `play` request it steps through a small song ROM. Each entry holds a note divisor and a duration in ticks.
- Between notes it inserts a short silent gap, so that repeated identical notes stay audible as separate notes.

Parameters:
- CLK_HZ, 50_000_000: system clock frequency. Documentation only; not used in logic.
- TICK_CYCLES, 2_500_000: clock cycles per duration tick (50 ms at 50 MHz). Must be ≥ 2.
- GAP_TICKS, 1: silent ticks between consecutive notes. 0 means no gap.
- SONG_LEN, 16: ROM entries per song (power of two).
- N_W, 12: width of the note divisor.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- play, input, 1: start request, sampled each cycle.
- stop, input, 1: abort request, sampled each cycle.
- song_sel, input, 2: song index, latched at start.
- N, output, N_W: note divisor to the tone generator. 0 = rest.
- tone_en, output, 1: 1 while a non-rest note sounds.
- busy, output, 1: 1 from start until return to IDLE.
- done, output, 1: one-cycle pulse when a song finishes naturally.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; N=0, tone_en=0, busy=0, done=0. Note index, tick counter and duration counter are all cleared.
- ROM entry format: {N[N_W-1:0], dur[3:0]}. dur=0 marks end-of-song. N=0 is a rest: full duration with tone_en=0.
- FSM states: IDLE, LOAD, NOTE, GAP, FIN.
- IDLE:
  - play=1 and stop=0 at edge k: latch song_sel, index=0, busy=1 at k+1, go to LOAD.
- LOAD (1 cycle):
  - Read ROM[song][index].
  - If dur=0, go to FIN.
  - Otherwise, at the next edge: N=entry N, tone_en=(N≠0), dur_cnt=dur, tick counter cleared, go to NOTE.
  - First audible output is 2 cycles after the play edge.
- NOTE:
  - Each tick (TICK_CYCLES cycles, counted from NOTE entry) decrements dur_cnt.
  - When dur_cnt reaches 0:
    - If index=SONG_LEN-1, go to FIN.
    - Else if GAP_TICKS=0, index++ and go to LOAD.
    - Else go to GAP.
  - N and tone_en hold constant for the whole note; no mid-note changes.
- GAP: N=0, tone_en=0 for GAP_TICKS ticks, then index++ and go to LOAD.
- FIN (1 cycle): N=0, tone_en=0, done=1, busy=0 on exit, then go to IDLE.
- stop=1 in any non-IDLE state: next edge goes to IDLE with N=0, tone_en=0, busy=0, and no done pulse.
- play and stop both high in IDLE: stop wins and nothing starts.
- play while busy: ignored, no restart.
- song_sel changes while busy: ignored until the next start.
- Index does not wrap: the song ends after SONG_LEN entries even if no dur=0 terminator is present.
- Tick counter width: clog2(TICK_CYCLES). It wraps to 0 at TICK_CYCLES-1, and the tick pulse fires on that cycle.
- Reset asserted mid-song: all outputs drop immediately (asynchronously), and no done pulse is produced.

Decomposition:
- Shared package/include melody_pkg:
  - state encoding localparams;
  - ROM entry field widths;
  - the 4×SONG_LEN song table (case-based ROM function), including note divisor constants (e.g. NOTE_C4, NOTE_E4, NOTE_G4, REST).
- One sub-module, dur_tick_gen:
  - parameter TICK_CYCLES;
  - inputs clk, reset, clr;
  - output tick (1-cycle pulse).
- FSM, ROM lookup and counters live in melody_sequencer.

Test Plan:
Bench settings: TICK_CYCLES=4, GAP_TICKS=1. Song 0 = {(100,2),(0,1),(200,1),(x,0)}.
- Reset/idle: reset low 3 cycles, then high with play=0 → N=0, tone_en=0, busy=0, done=0 for 50 cycles.
- Song 0 full play: play pulse at edge k → busy=1 at k+1; N=100 and tone_en=1 at k+2 for 8 cycles; gap 4 cycles; N=0 and tone_en=0 rest for 4 cycles; gap 4 cycles; N=200 for 4 cycles; one-cycle done; busy=0 next cycle.
- Abort: stop=1 three cycles into the first note → next edge N=0, tone_en=0, busy=0, no done pulse. A subsequent play restarts from index 0 with N=100.
- Ignored requests:
  - play re-pulsed mid-song → timing identical to the uninterrupted run;
  - play and stop high together in IDLE → busy stays 0.
- No terminator: song 3 filled with 16 entries of dur=1 → exactly 16 notes, then done. The index never reads entry 0 again.
- Async reset mid-note: reset low between clock edges → N=0 and busy=0 before the next edge. After release, idle with no done pulse.
